// File: rtl/propagate_arbiter.sv
// Round-robin front end that shares one carry-propagate / SM2 mod-p reduction
// unit among several requesters, with one operation in flight at a time.

module adder_propagate #(
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17,
    parameter int WORD_LEN     = 16,
    parameter int DATA_LEN     = 256
) (
    input  logic [BIT_LEN-1:0]  A [NUM_ELEMENTS],
    output logic [DATA_LEN-1:0] Propagated_A
);

    localparam int SUM_W = DATA_LEN + 2;
    localparam logic [DATA_LEN-1:0] P_MOD =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic [SUM_W-1:0]    sum_s;
    logic [1:0]          k_s;
    logic [DATA_LEN-1:0] kp_s;

    // Weighted limb sum; limb bits beyond the window fall off the top.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            sum_s = sum_s + (SUM_W'(A[i]) << (WORD_LEN * i));
        end
    end

    // k*p only matters modulo 2^DATA_LEN since the result is DATA_LEN bits wide.
    always_comb begin
        k_s = sum_s[SUM_W-1:DATA_LEN];
        case (k_s)
            2'd0:    kp_s = '0;
            2'd1:    kp_s = P_MOD;
            2'd2:    kp_s = P_MOD << 1;
            2'd3:    kp_s = P_MOD + (P_MOD << 1);
            default: kp_s = '0;
        endcase
    end

    // Final subtraction of the folded overflow multiple of p.
    always_comb begin
        Propagated_A = sum_s[DATA_LEN-1:0] - kp_s;
    end

endmodule

module propagate_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17,
    parameter int WORD_LEN     = 16,
    parameter int DATA_LEN     = 256,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [BIT_LEN-1:0]  req_A [NUM_REQ][NUM_ELEMENTS],
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_LEN-1:0] res_data,
    output logic [ID_W-1:0]     res_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     id_reg_r;
    logic [BIT_LEN-1:0]  op_reg_r [NUM_ELEMENTS];
    logic [ID_W-1:0]     winner_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [ID_W-1:0]     idx_s;
    logic                grant_s;
    logic [DATA_LEN-1:0] prop_s;

    adder_propagate #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .BIT_LEN      (BIT_LEN),
        .WORD_LEN     (WORD_LEN),
        .DATA_LEN     (DATA_LEN)
    ) u_adder_propagate (
        .A            (op_reg_r),
        .Propagated_A (prop_s)
    );

    // Round-robin scan: walking offsets from far to near lets the nearest valid win.
    always_comb begin
        winner_s = rr_ptr_r;
        idx_s    = rr_ptr_r;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx_s = ID_W'((int'(rr_ptr_r) + off) % NUM_REQ);
            if (req_valid[idx_s]) begin
                winner_s = idx_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Grant is possible when idle, or when the held result is being consumed.
    always_comb begin
        grant_s = rst_n && (|req_valid) &&
                  ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && res_ready));
        if (winner_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + ID_W'(1);
        end
    end

    // One-hot grant decode.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = grant_s && (winner_s == ID_W'(j));
        end
    end

    // Control FSM with operand capture and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            id_reg_r  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            for (int e = 0; e < NUM_ELEMENTS; e++) begin
                op_reg_r[e] <= '0;
            end
        end else begin
            if (grant_s) begin
                id_reg_r <= winner_s;
                rr_ptr_r <= next_ptr_s;
                for (int e = 0; e < NUM_ELEMENTS; e++) begin
                    op_reg_r[e] <= req_A[winner_s][e];
                end
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= grant_s ? ST_CALC : ST_IDLE;
                end
                ST_CALC: begin
                    res_data  <= prop_s;
                    res_id    <= id_reg_r;
                    res_valid <= 1'b1;
                    state_r   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_r   <= grant_s ? ST_CALC : ST_IDLE;
                    end else begin
                        state_r   <= ST_HOLD;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_propagate_arbiter.sv
// Directed plus randomized bench for propagate_arbiter against a behavioural
// model of the arbitration order and the propagate/reduce arithmetic.

module tb_propagate_arbiter;

    localparam int NR = 4;
    localparam int NE = 17;
    localparam int BL = 17;
    localparam int DL = 256;
    localparam logic [DL-1:0] P_SM2 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [BL-1:0] req_A [NR][NE];
    logic          res_valid;
    logic          res_ready;
    logic [DL-1:0] res_data;
    logic [1:0]    res_id;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an operation is computing, or a result is being held.
    bit            m_calc = 1'b0;
    bit            m_hold = 1'b0;
    bit            m_valid = 1'b0;
    int            m_ptr = 0;
    int            m_op_id = 0;
    int            m_res_id = 0;
    logic [DL-1:0] m_op_res = '0;
    logic [DL-1:0] m_res_data = '0;
    bit            e_grant;
    int            e_win;

    propagate_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A     (req_A),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DL-1:0] ref_prop(input logic [BL-1:0] a [NE]);
        logic [299:0] s;
        int           k;
        s = '0;
        for (int i = 0; i < NE; i++) begin
            s = s + (300'(a[i]) << (16 * i));
        end
        s = s & ((300'(1) << 258) - 300'(1));
        k = int'(s >> 256);
        s = s - 300'(k) * 300'(P_SM2);
        return s[DL-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, then compare everything at the falling edge.
    task automatic drive(input logic [NR-1:0] v, input logic rr);
        logic [NR-1:0] exp_rdy;
        req_valid = v;
        res_ready = rr;
        #4;
        e_grant = rst_n && !m_calc && (!m_hold || rr) && (v != '0);
        e_win   = -1;
        for (int o = 0; o < NR; o++) begin
            if (e_win < 0 && v[(m_ptr + o) % NR]) e_win = (m_ptr + o) % NR;
        end
        exp_rdy = '0;
        if (e_grant) exp_rdy[e_win] = 1'b1;
        chk("req_ready", DL'(req_ready), DL'(exp_rdy));
        chk("res_valid", DL'(res_valid), DL'(m_valid));
        chk("busy", DL'(busy), DL'(m_calc || m_hold));
        chk("res_data", res_data, m_res_data);
        chk("res_id", DL'(res_id), DL'(m_res_id));
        chk("onehot", DL'($countones(req_ready) <= 1), DL'(1));
    endtask

    task automatic tick();
        logic [BL-1:0] a [NE];
        @(posedge clk);
        if (!rst_n) begin
            m_calc = 1'b0; m_hold = 1'b0; m_valid = 1'b0;
            m_ptr = 0; m_res_id = 0; m_res_data = '0;
        end else if (m_calc) begin
            m_res_data = m_op_res; m_res_id = m_op_id;
            m_valid = 1'b1; m_calc = 1'b0; m_hold = 1'b1;
        end else if (e_grant) begin
            for (int e = 0; e < NE; e++) a[e] = req_A[e_win][e];
            m_op_res = ref_prop(a); m_op_id = e_win;
            m_calc = 1'b1; m_hold = 1'b0; m_valid = 1'b0;
            m_ptr = (e_win + 1) % NR;
        end else if (m_hold && res_ready) begin
            m_hold = 1'b0; m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic one_op(input int id, input logic [DL-1:0] expd);
        logic [NR-1:0] v;
        v = '0;
        v[id] = 1'b1;
        drive(v, 1'b0);
        chk("op_grant", DL'(req_ready), DL'(v));
        tick();
        // Operand changes after the handshake must not reach the result.
        for (int e = 0; e < NE; e++) req_A[id][e] = BL'($urandom);
        drive('0, 1'b0);
        chk("op_calc_busy", DL'(busy), DL'(1));
        chk("op_calc_valid", DL'(res_valid), DL'(0));
        tick();
        drive('0, 1'b0);
        chk("op_res_valid", DL'(res_valid), DL'(1));
        chk("op_res_data", res_data, expd);
        chk("op_res_id", DL'(res_id), DL'(id));
        tick();
        drive('0, 1'b1);
        tick();
        drive('0, 1'b0);
        chk("op_idle_busy", DL'(busy), DL'(0));
        tick();
    endtask

    task automatic clear_ops();
        for (int r = 0; r < NR; r++)
            for (int e = 0; e < NE; e++) req_A[r][e] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int            grants[$];
        int            exp_order[5];
        logic [DL-1:0] snap_data;
        logic [1:0]    snap_id;
        exp_order = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        clear_ops();
        @(posedge clk);
        #1;
        drive('0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive('0, 1'b0);
        chk("rst_res_valid", DL'(res_valid), DL'(0));
        chk("rst_res_data", res_data, '0);
        chk("rst_busy", DL'(busy), DL'(0));
        tick();

        clear_ops();
        req_A[2][0] = 17'h00001;
        one_op(2, 256'h1);

        clear_ops();
        req_A[0][0] = 17'h10000;
        req_A[0][1] = 17'h1FFFF;
        one_op(0, 256'h2_0000_0000);

        clear_ops();
        req_A[1][16] = 17'h00001;
        one_op(1, 256'h00000001_00000000_00000000_00000000_00000000_ffffffff_00000000_00000001);

        // Round-robin with every requester pending and the consumer always ready.
        do_reset();
        for (int r = 0; r < NR; r++)
            for (int e = 0; e < NE; e++) req_A[r][e] = BL'($urandom);
        for (int c = 0; c < 10; c++) begin
            drive('1, 1'b1);
            if (req_ready != '0) grants.push_back($clog2(req_ready));
            tick();
        end
        chk("rr_grant_count", DL'(grants.size()), DL'(5));
        for (int g = 0; g < 5 && g < grants.size(); g++) begin
            chk("rr_order", DL'(grants[g]), DL'(exp_order[g]));
        end

        // Backpressure in HOLD, then same-cycle regrant on release.
        drive('1, 1'b0);
        snap_data = res_data;
        snap_id   = res_id;
        tick();
        for (int c = 0; c < 4; c++) begin
            drive('1, 1'b0);
            chk("bp_ready", DL'(req_ready), DL'(0));
            chk("bp_data_stable", res_data, snap_data);
            chk("bp_id_stable", DL'(res_id), DL'(snap_id));
            tick();
        end
        drive('1, 1'b1);
        chk("bp_release_grant", DL'(req_ready), DL'(4'b0010));
        tick();
        drive('0, 1'b0);
        tick();
        drive('0, 1'b1);
        tick();

        // Reset during CALC discards the operation and rewinds the pointer.
        drive(4'b1000, 1'b0);
        chk("mid_grant", DL'(req_ready), DL'(4'b1000));
        tick();
        do_reset();
        drive('0, 1'b0);
        chk("mid_rst_valid", DL'(res_valid), DL'(0));
        chk("mid_rst_busy", DL'(busy), DL'(0));
        tick();
        drive('0, 1'b0);
        chk("mid_no_result", DL'(res_valid), DL'(0));
        tick();
        drive('1, 1'b0);
        chk("mid_ptr_zero", DL'(req_ready), DL'(4'b0001));
        tick();
        drive('0, 1'b0);
        tick();
        drive('0, 1'b1);
        tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int r = 0; r < NR; r++)
                for (int e = 0; e < NE; e++) req_A[r][e] = BL'($urandom);
            drive(NR'($urandom), 1'($urandom));
            tick();
        end
        rst_n = 1'b1;
        drive('0, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/propagate_arbiter.md
Name: propagate_arbiter

Overview:
- Shares one `adder_propagate` carry-propagate/mod-p reduction unit (SM2 p) among NUM_REQ requesters, e.g. the ladder's multiplier and add/sub lanes.
- Each requester supplies a redundant-form operand of NUM_ELEMENTS limbs of BIT_LEN bits.
- The block arbitrates round-robin, registers the granted operand, drives the shared unit, and returns the 256-bit result tagged with the requester index.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_ELEMENTS, 17, limbs per operand.
- BIT_LEN, 17, bits per limb.
- WORD_LEN, 16, limb weight shift (limb i has weight 2^(16*i)).
- DATA_LEN, 256, result width.
- ID_W, $clog2(NUM_REQ), requester tag width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  [NUM_REQ]  requester i has an operand.
- req_ready  out  [NUM_REQ]  grant; handshake when req_valid[i] & req_ready[i].
- req_A  in  [NUM_REQ][NUM_ELEMENTS][BIT_LEN]  unpacked operand per requester.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_LEN  propagated/reduced result.
- res_id  out  ID_W  index of the requester the result belongs to.
- busy  out  1  high in CALC or HOLD.

Behaviour:
- Reset is synchronous, active-low, single clock domain. While rst_n=0 at a clk edge:
  - state goes to IDLE, rr_ptr to 0;
  - res_valid, res_data, res_id and the operand register go to 0;
  - req_ready is all 0 and busy is 0.
- States:
  - IDLE: no work. If any req_valid is set, grant the winner (assert its req_ready, combinationally, same cycle), load req_A[winner] into op_reg and winner into id_reg, then go to CALC.
  - CALC: op_reg drives the `adder_propagate` instance. At the clock edge, latch Propagated_A into res_data and id_reg into res_id, set res_valid=1, then go to HOLD.
  - HOLD: res_valid=1; res_data and res_id are held stable.
    - res_ready=0: stay.
    - res_ready=1 and some req_valid: accept the new grant in the same cycle (res_valid drops, op_reg loads), go to CALC.
    - res_ready=1 and no req_valid: res_valid=0, go to IDLE.
- Latency: grant handshake at edge T gives res_valid=1 after edge T+1, i.e. visible in cycle T+2. Peak throughput is one result per 2 cycles.
- Arbitration:
  - Winner is the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - After a grant to i, rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr is unchanged when no grant occurs.
  - At most one req_ready bit is high; it is never high in CALC, or in HOLD while res_ready=0.
  - req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
- Arithmetic:
  - res_data equals the unit output: sum = Σ A[i]·2^(16i) in DATA_LEN+2 bits, minus k·p, where k = sum[DATA_LEN+1:DATA_LEN].
  - The result is congruent to sum mod p and may still be ≥ p; no further reduction here.
  - Bits of limbs above bit 16 are carried through by the unit unchanged in meaning.
- Operand capture: only on a handshake. Requester changes to req_A after its handshake do not affect the result.
- Boundaries:
  - A requester dropping req_valid before it is granted is simply skipped.
  - Simultaneous res_ready and new request in HOLD is handled as above, with no bubble and no lost result.
  - Reset asserted mid-CALC/HOLD discards the operation. No res_valid pulse follows reset.

Test Plan:
- Single op: req 2 with A[0]=17'h00001, others 0 → req_ready[2] same cycle; res_valid two cycles later with res_data=256'h1, res_id=2; busy high during CALC/HOLD.
- Carry: req 0 with A[0]=17'h10000, A[1]=17'h1FFFF → res_data = 2^16 + 17'h1FFFF·2^16 = 256'h2_0000_0000 (i.e. 0x200000000).
- Reduction: A[16]=17'h1, others 0 (sum=2^256) → res_data = 256'h00000001_00000000_00000000_00000000_00000000_ffffffff_00000000_00000001.
- Round-robin: all four req_valid held high with res_ready=1 → grants in order 0,1,2,3,0, each 2 cycles apart; res_id sequence matches; never two req_ready high.
- Backpressure: res_ready=0 for 5 cycles in HOLD with requests pending → res_data/res_id stable, req_ready all 0. Raising res_ready grants the next requester in that same cycle.
- Reset mid-op: rst_n=0 for one cycle during CALC → next cycle state IDLE, res_valid=0, rr_ptr=0, and no result is emitted for the aborted op.
